alarm_sequencer: RTL and testbench

Sequences the alarm comparator: drives its enable, turns its latched match into a bounded ringing episode, and handles snooze, stop, ring timeout and re-arm. Sits between the alarm comparator, the seconds tick from the clock counter, the user buttons and the buzzer output. All outputs are registered.

---
 rtl/alarm_sequencer.sv | 152 +++++++++++++++
 tb/tb_alarm_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: enables the alarm comparator and turns a match into a ringing episode with snooze, stop and timeout; ALARM_BEEP_PATTERN_EN gives a 1 s on/off buzzer.
// Latency: a qualifying input in one cycle shows on the registered state and outputs in the next cycle.
// Backpressure: none; buttons are raw levels edge-detected here, tick is a one-cycle strobe.
module alarm_sequencer #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic       alarm_hit,
    input  logic       tick,
    input  logic       snooze,
    input  logic       stop,
    output logic       alarm_enable,
    output logic       buzzer,
    output logic [2:0] state,
    output logic [8:0] snooze_left,
    output logic [1:0] snooze_count
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RINGING = 3'd2,
        ST_SNOOZED = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SEC);
    localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_SEC - 1);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t     state_q, state_d;
    logic       alarm_enable_q, alarm_enable_d;
    logic       buzzer_q, buzzer_d;
    logic [8:0] snooze_left_q, snooze_left_d;
    logic [1:0] snooze_count_q, snooze_count_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       snooze_prev_q, stop_prev_q;
    logic       snooze_edge, stop_edge;

    assign snooze_edge = snooze & ~snooze_prev_q;
    assign stop_edge   = stop & ~stop_prev_q;

    always_comb begin
        state_d        = state_q;
        snooze_left_d  = snooze_left_q;
        snooze_count_d = snooze_count_q;
        ring_cnt_d     = ring_cnt_q;

        if (!arm) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_CLEAR;
                // Holding off one tick lets the comparator latch clear and the matching second pass.
                ST_CLEAR: begin
                    if (tick) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (alarm_hit) begin
                        state_d        = ST_RINGING;
                        ring_cnt_d     = 8'd0;
                        snooze_count_d = 2'd0;
                    end
                end
                ST_RINGING: begin
                    if (stop_edge) begin
                        state_d = ST_CLEAR;
                    end else if (snooze_edge) begin
                        if (snooze_count_q < SNOOZE_MAX) begin
                            state_d        = ST_SNOOZED;
                            snooze_left_d  = SNOOZE_LOAD;
                            snooze_count_d = snooze_count_q + 2'd1;
                        end else begin
                            state_d = ST_CLEAR;
                        end
                    end else if (tick) begin
                        if (ring_cnt_q == RING_LAST) state_d = ST_CLEAR;
                        else                         ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
                ST_SNOOZED: begin
                    if (stop_edge) begin
                        state_d = ST_CLEAR;
                    end else if (tick) begin
                        if (snooze_left_q == 9'd1) begin
                            state_d       = ST_RINGING;
                            snooze_left_d = 9'd0;
                            ring_cnt_d    = 8'd0;
                        end else begin
                            snooze_left_d = snooze_left_q - 9'd1;
                        end
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        if (state_d == ST_OFF || state_d == ST_CLEAR) begin
            snooze_count_d = 2'd0;
            snooze_left_d  = 9'd0;
        end

        // Every exit from RINGING lands in a state with the enable low for at least a cycle.
        alarm_enable_d = (state_d == ST_ARMED) || (state_d == ST_RINGING);

`ifdef ALARM_BEEP_PATTERN_EN
        if (state_d != ST_RINGING)
            buzzer_d = 1'b0;
        else if (state_q != ST_RINGING)
            buzzer_d = 1'b1;
        else if (tick && !stop_edge && !snooze_edge)
            buzzer_d = ~buzzer_q;
        else
            buzzer_d = buzzer_q;
`else
        buzzer_d = (state_d == ST_RINGING);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_OFF;
            alarm_enable_q <= 1'b0;
            buzzer_q       <= 1'b0;
            snooze_left_q  <= 9'd0;
            snooze_count_q <= 2'd0;
            ring_cnt_q     <= 8'd0;
            snooze_prev_q  <= 1'b0;
            stop_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            alarm_enable_q <= alarm_enable_d;
            buzzer_q       <= buzzer_d;
            snooze_left_q  <= snooze_left_d;
            snooze_count_q <= snooze_count_d;
            ring_cnt_q     <= ring_cnt_d;
            snooze_prev_q  <= snooze;
            stop_prev_q    <= stop;
        end
    end

    assign state        = state_q;
    assign alarm_enable = alarm_enable_q;
    assign buzzer       = buzzer_q;
    assign snooze_left  = snooze_left_q;
    assign snooze_count = snooze_count_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: expected outputs are queued as each cycle is driven and compared against the sampled outputs.
module tb_alarm_sequencer;

    localparam int SNOOZE_SEC       = 3;
    localparam int RING_TIMEOUT_SEC = 4;
    localparam int MAX_SNOOZE       = 2;
`ifdef ALARM_BEEP_PATTERN_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       en;
        logic       bz;
        logic [8:0] sl;
        logic [1:0] sc;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       arm, alarm_hit, tick, snooze, stop;
    logic       alarm_enable, buzzer;
    logic [2:0] state;
    logic [8:0] snooze_left;
    logic [1:0] snooze_count;

    obs_t exp_q[$];
    obs_t got_q[$];
    int   checks = 0;
    int   errors = 0;

    alarm_sequencer #(
        .SNOOZE_SEC      (SNOOZE_SEC),
        .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC),
        .MAX_SNOOZE      (MAX_SNOOZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .alarm_hit   (alarm_hit),
        .tick        (tick),
        .snooze      (snooze),
        .stop        (stop),
        .alarm_enable(alarm_enable),
        .buzzer      (buzzer),
        .state       (state),
        .snooze_left (snooze_left),
        .snooze_count(snooze_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int st, input bit en, input bit bz, input int sl, input int sc);
        obs_t o;
        o.st = 3'(st);
        o.en = en;
        o.bz = bz;
        o.sl = 9'(sl);
        o.sc = 2'(sc);
        return o;
    endfunction

    // k = ticks counted since RINGING entry
    function automatic bit ring_bz(input int k);
        return BEEP ? (k % 2 == 0) : 1'b1;
    endfunction

    function automatic obs_t ring(input int k, input int sc);
        return mk(2, 1'b1, ring_bz(k), 0, sc);
    endfunction

    function automatic obs_t snz(input int sl, input int sc);
        return mk(3, 1'b0, 1'b0, sl, sc);
    endfunction

    function automatic obs_t sample();
        return {state, alarm_enable, buzzer, snooze_left, snooze_count};
    endfunction

    localparam obs_t ZERO    = '0;
    localparam obs_t ARMED_E = 16'b001_1_0_000000000_00;
    localparam obs_t CLEAR_E = 16'b100_0_0_000000000_00;

    task automatic cyc(input bit a, input bit h, input bit t, input bit sn, input bit sp, input obs_t e);
        arm       = a;
        alarm_hit = h;
        tick      = t;
        snooze    = sn;
        stop      = sp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got_q.push_back(sample());
    endtask

    task automatic test_reset();
        obs_t e, g;
        #12;
        exp_q.push_back(ZERO);
        got_q.push_back(sample());
        arm = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(ZERO);
        got_q.push_back(sample());
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0, CLEAR_E);
        cyc(1, 0, 0, 0, 0, CLEAR_E);
        cyc(1, 0, 1, 0, 0, ARMED_E);
        cyc(1, 0, 0, 0, 0, ARMED_E);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_arm step %0d: got st=%0d en=%0b bz=%0b sl=%0d sc=%0d, expected st=%0d en=%0b bz=%0b sl=%0d sc=%0d",
                         i, g.st, g.en, g.bz, g.sl, g.sc, e.st, e.en, e.bz, e.sl, e.sc);
            end
        end
    endtask

    task automatic test_ring_stop();
        obs_t e, g;
        cyc(1, 1, 0, 0, 0, ring(0, 0));
        cyc(1, 1, 0, 0, 1, CLEAR_E);
        cyc(1, 0, 0, 0, 1, CLEAR_E);
        cyc(1, 0, 1, 0, 1, ARMED_E);
        cyc(1, 1, 0, 0, 1, ring(0, 0));   // held stop level is not an edge
        cyc(1, 0, 0, 0, 0, ring(0, 0));
        cyc(1, 0, 0, 0, 1, CLEAR_E);
        cyc(1, 0, 1, 0, 0, ARMED_E);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL ring_stop step %0d: got st=%0d en=%0b bz=%0b sl=%0d sc=%0d, expected st=%0d en=%0b bz=%0b sl=%0d sc=%0d",
                         i, g.st, g.en, g.bz, g.sl, g.sc, e.st, e.en, e.bz, e.sl, e.sc);
            end
        end
    endtask

    task automatic test_snooze();
        obs_t e, g;
        cyc(1, 1, 0, 0, 0, ring(0, 0));
        cyc(1, 0, 0, 1, 0, snz(3, 1));
        cyc(1, 0, 1, 1, 0, snz(2, 1));
        cyc(1, 0, 0, 0, 0, snz(2, 1));
        cyc(1, 0, 1, 0, 0, snz(1, 1));
        cyc(1, 0, 1, 0, 0, ring(0, 1));
        cyc(1, 0, 0, 0, 0, ring(0, 1));
        cyc(1, 0, 0, 0, 1, CLEAR_E);
        cyc(1, 0, 1, 0, 0, ARMED_E);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL snooze step %0d: got st=%0d en=%0b bz=%0b sl=%0d sc=%0d, expected st=%0d en=%0b bz=%0b sl=%0d sc=%0d",
                         i, g.st, g.en, g.bz, g.sl, g.sc, e.st, e.en, e.bz, e.sl, e.sc);
            end
        end
    endtask

    task automatic test_snooze_limit();
        obs_t e, g;
        cyc(1, 1, 0, 0, 0, ring(0, 0));
        for (int n = 1; n <= MAX_SNOOZE; n++) begin
            cyc(1, 0, 0, 1, 0, snz(3, n));
            cyc(1, 0, 1, 0, 0, snz(2, n));
            cyc(1, 0, 1, 0, 0, snz(1, n));
            cyc(1, 0, 1, 0, 0, ring(0, n));
        end
        cyc(1, 0, 0, 1, 0, CLEAR_E);
        cyc(1, 0, 1, 0, 0, ARMED_E);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL snooze_limit step %0d: got st=%0d en=%0b bz=%0b sl=%0d sc=%0d, expected st=%0d en=%0b bz=%0b sl=%0d sc=%0d",
                         i, g.st, g.en, g.bz, g.sl, g.sc, e.st, e.en, e.bz, e.sl, e.sc);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t e, g;
        cyc(1, 1, 0, 0, 0, ring(0, 0));
        cyc(1, 0, 1, 0, 0, ring(1, 0));
        cyc(1, 0, 0, 0, 0, ring(1, 0));
        cyc(1, 0, 1, 0, 0, ring(2, 0));
        cyc(1, 0, 1, 0, 0, ring(3, 0));
        cyc(1, 0, 1, 0, 0, CLEAR_E);
        cyc(1, 0, 1, 0, 0, ARMED_E);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL timeout step %0d: got st=%0d en=%0b bz=%0b sl=%0d sc=%0d, expected st=%0d en=%0b bz=%0b sl=%0d sc=%0d",
                         i, g.st, g.en, g.bz, g.sl, g.sc, e.st, e.en, e.bz, e.sl, e.sc);
            end
        end
    endtask

    task automatic test_simul_abort();
        obs_t e, g;
        cyc(1, 1, 0, 0, 0, ring(0, 0));
        cyc(1, 0, 0, 1, 1, CLEAR_E);
        cyc(1, 0, 1, 0, 0, ARMED_E);
        cyc(1, 1, 0, 0, 0, ring(0, 0));
        cyc(1, 0, 0, 1, 0, snz(3, 1));
        cyc(0, 0, 0, 0, 0, ZERO);
        cyc(1, 0, 0, 0, 0, CLEAR_E);
        cyc(1, 0, 1, 0, 0, ARMED_E);
        cyc(1, 1, 0, 0, 0, ring(0, 0));
        cyc(1, 0, 1, 0, 0, ring(1, 0));
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(ZERO);
        got_q.push_back(sample());
        arm  = 1'b0;
        tick = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(ZERO);
        got_q.push_back(sample());
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, ZERO);
        cyc(1, 0, 0, 0, 0, CLEAR_E);
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL simul_abort step %0d: got st=%0d en=%0b bz=%0b sl=%0d sc=%0d, expected st=%0d en=%0b bz=%0b sl=%0d sc=%0d",
                         i, g.st, g.en, g.bz, g.sl, g.sc, e.st, e.en, e.bz, e.sl, e.sc);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        arm       = 1'b0;
        alarm_hit = 1'b0;
        tick      = 1'b0;
        snooze    = 1'b0;
        stop      = 1'b0;
        test_reset();
        test_ring_stop();
        test_snooze();
        test_snooze_limit();
        test_timeout();
        test_simul_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
